// File: rtl/race_game_core.sv
// N-player click-race engine: per-player step counting, red-light penalties,
// finish ranking with winner capture, and a round-robin display scanner.
module race_game_core #(
  parameter int N_PLAYERS     = 4,
  parameter int SCAN_DIV      = 100,
  parameter int CLICK_W       = 5,
  parameter int STEP_W        = 3,
  parameter int STOP_AT_FIRST = 0,
  localparam int PW           = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 red,
  input  logic [CLICK_W-1:0]   max_clicks,
  input  logic [STEP_W-1:0]    max_steps,
  input  logic [N_PLAYERS-1:0] click,
  output logic [PW-1:0]        scan_player,
  output logic [STEP_W-1:0]    scan_position,
  output logic [3:0]           scan_status,
  output logic [N_PLAYERS-1:0] finished,
  output logic                 winner_valid,
  output logic [PW-1:0]        winner_id,
  output logic                 game_over
);
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [CLICK_W-1:0]   mc, mc_next;
  logic [STEP_W-1:0]    ms, ms_next;
  logic [STEP_W-1:0]    pos [N_PLAYERS];
  logic [STEP_W-1:0]    pos_next [N_PLAYERS];
  logic [CLICK_W-1:0]   cnt [N_PLAYERS];
  logic [CLICK_W-1:0]   cnt_next [N_PLAYERS];
  logic [2:0]           rank [N_PLAYERS];
  logic [2:0]           rank_next [N_PLAYERS];
  logic [N_PLAYERS-1:0] penalty, penalty_next;
  logic [N_PLAYERS-1:0] finished_next;
  logic [3:0]           next_rank, next_rank_next;
  logic                 winner_valid_next;
  logic [PW-1:0]        winner_id_next;
  logic [N_PLAYERS-1:0] click_prev, click_event;
  logic [SCW-1:0]       scan_cnt;

  generate
    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_edge
      assign click_event[gi] = click[gi] & ~click_prev[gi];
    end
  endgenerate

  always_comb begin
    state_next        = state;
    mc_next           = mc;
    ms_next           = ms;
    pos_next          = pos;
    cnt_next          = cnt;
    rank_next         = rank;
    penalty_next      = penalty;
    finished_next     = finished;
    next_rank_next    = next_rank;
    winner_valid_next = winner_valid;
    winner_id_next    = winner_id;
    case (state)
      RUN: begin
        // Ascending index order gives the lower index the lower rank on ties.
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (click_event[i] && !finished[i]) begin
            if (red) begin
              cnt_next[i]     = '0;
              pos_next[i]     = '0;
              penalty_next[i] = 1'b1;
            end else begin
              penalty_next[i] = 1'b0;
              if (({1'b0, cnt[i]} + 1'b1) == {1'b0, mc}) begin
                cnt_next[i] = '0;
                pos_next[i] = pos[i] + 1'b1;
                if (pos_next[i] == ms) begin
                  finished_next[i] = 1'b1;
                  rank_next[i]     = next_rank_next[2:0];
                  next_rank_next   = next_rank_next + 1'b1;
                  if (!winner_valid_next) begin
                    winner_valid_next = 1'b1;
                    winner_id_next    = PW'(i);
                  end
                end
              end else begin
                cnt_next[i] = cnt[i] + 1'b1;
              end
            end
          end
        end
        if ((STOP_AT_FIRST != 0) ? (|finished_next) : (&finished_next))
          state_next = DONE;
      end
      default: begin
        if (start) begin
          state_next        = RUN;
          mc_next           = (max_clicks == '0) ? CLICK_W'(1) : max_clicks;
          ms_next           = (max_steps == '0) ? STEP_W'(1) : max_steps;
          penalty_next      = '0;
          finished_next     = '0;
          next_rank_next    = 4'd1;
          winner_valid_next = 1'b0;
          winner_id_next    = '0;
          for (int i = 0; i < N_PLAYERS; i++) begin
            pos_next[i]  = '0;
            cnt_next[i]  = '0;
            rank_next[i] = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mc           <= '0;
      ms           <= '0;
      penalty      <= '0;
      finished     <= '0;
      next_rank    <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      click_prev   <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        pos[i]  <= '0;
        cnt[i]  <= '0;
        rank[i] <= '0;
      end
    end else begin
      state        <= state_next;
      mc           <= mc_next;
      ms           <= ms_next;
      pos          <= pos_next;
      cnt          <= cnt_next;
      rank         <= rank_next;
      penalty      <= penalty_next;
      finished     <= finished_next;
      next_rank    <= next_rank_next;
      winner_valid <= winner_valid_next;
      winner_id    <= winner_id_next;
      click_prev   <= click;
    end
  end

  // Explicit wrap so non-power-of-two SCAN_DIV and N_PLAYERS behave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      scan_player <= '0;
    end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
      scan_cnt    <= '0;
      scan_player <= (scan_player == PW'(N_PLAYERS - 1)) ? '0 : scan_player + 1'b1;
    end else begin
      scan_cnt    <= scan_cnt + 1'b1;
    end
  end

  assign game_over     = (state == DONE);
  assign scan_position = pos[scan_player];

  always_comb begin
    scan_status = 4'b0000;
    if (finished[scan_player])
      scan_status = {1'b1, rank[scan_player]};
    else if (penalty[scan_player])
      scan_status = 4'b0010;
    else if (state == RUN)
      scan_status = 4'b0001;
  end
endmodule

// File: tb/tb_race_game_core.sv
// Bench for race_game_core: directed vector table, scanner/stop-at-first/reset
// sequences, and randomized play against a click-count reference model.
module tb_race_game_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, red;
  logic [4:0] max_clicks;
  logic [2:0] max_steps;
  logic [3:0] click_a;
  logic [2:0] click_b;
  logic [4:0] click_c;

  logic [1:0] sp_a, wid_a;
  logic [2:0] pos_a;
  logic [3:0] st_a, fin_a;
  logic       wv_a, go_a;
  logic [1:0] sp_b, wid_b;
  logic [2:0] pos_b, fin_b;
  logic [3:0] st_b;
  logic       wv_b, go_b;
  logic [2:0] sp_c, wid_c, pos_c;
  logic [3:0] st_c;
  logic [4:0] fin_c;
  logic       wv_c, go_c;

  race_game_core #(.N_PLAYERS(4), .SCAN_DIV(1), .CLICK_W(5), .STEP_W(3), .STOP_AT_FIRST(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .red(red), .max_clicks(max_clicks),
    .max_steps(max_steps), .click(click_a), .scan_player(sp_a), .scan_position(pos_a),
    .scan_status(st_a), .finished(fin_a), .winner_valid(wv_a), .winner_id(wid_a),
    .game_over(go_a));

  race_game_core #(.N_PLAYERS(3), .SCAN_DIV(5), .CLICK_W(5), .STEP_W(3), .STOP_AT_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .red(red), .max_clicks(max_clicks),
    .max_steps(max_steps), .click(click_b), .scan_player(sp_b), .scan_position(pos_b),
    .scan_status(st_b), .finished(fin_b), .winner_valid(wv_b), .winner_id(wid_b),
    .game_over(go_b));

  race_game_core #(.N_PLAYERS(5), .SCAN_DIV(2), .CLICK_W(5), .STEP_W(3), .STOP_AT_FIRST(1)) dut_c (
    .clk(clk), .rst(rst), .start(start), .red(red), .max_clicks(max_clicks),
    .max_steps(max_steps), .click(click_c), .scan_player(sp_c), .scan_position(pos_c),
    .scan_status(st_c), .finished(fin_c), .winner_valid(wv_c), .winner_id(wid_c),
    .game_over(go_c));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mask; int red; int pp; int pos; int st; int fin; int wv; int wid; int go;
  } vec_t;
  vec_t tbl [27];

  // Reference model for instance A: position is valid clicks since the last
  // penalty divided by the clicks-per-step; ranks follow finish order.
  int m_vc [4];
  int m_pen [4];
  int m_fin [4];
  int m_rank [4];
  int m_nr, m_mc, m_ms, m_st, m_wv, m_wid, m_scan;
  logic [3:0] m_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_a(input logic [3:0] m, input logic r);
    @(negedge clk); click_a = m; red = r;
    @(negedge clk); click_a = '0; red = 1'b0;
  endtask

  task automatic pulse_c(input logic [4:0] m);
    @(negedge clk); click_c = m;
    @(negedge clk); click_c = '0;
  endtask

  task automatic peek_a(input int p, input int epos, input int est, input string name);
    int n = 0;
    while (sp_a !== 2'(p) && n < 16) begin @(negedge clk); n++; end
    chk({name, "_sp"}, 32'(sp_a), p);
    chk({name, "_pos"}, 32'(pos_a), epos);
    chk({name, "_st"}, 32'(st_a), est);
  endtask

  task automatic peek_c(input int p, input int epos, input int est, input string name);
    int n = 0;
    while (sp_c !== 3'(p) && n < 20) begin @(negedge clk); n++; end
    chk({name, "_sp"}, 32'(sp_c), p);
    chk({name, "_pos"}, 32'(pos_c), epos);
    chk({name, "_st"}, 32'(st_c), est);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_vc[i] = 0; m_pen[i] = 0; m_fin[i] = 0; m_rank[i] = 0;
    end
    m_nr = 0; m_mc = 1; m_ms = 1; m_st = 0; m_wv = 0; m_wid = 0; m_scan = 0;
    m_prev = '0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic r, input logic s,
                            input int mcv, input int msv);
    int all;
    if (m_st == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (c[i] && !m_prev[i] && m_fin[i] == 0) begin
          if (r) begin
            m_vc[i] = 0; m_pen[i] = 1;
          end else begin
            m_vc[i]++; m_pen[i] = 0;
            if (m_vc[i] / m_mc == m_ms) begin
              m_fin[i] = 1; m_rank[i] = m_nr; m_nr++;
              if (m_wv == 0) begin m_wv = 1; m_wid = i; end
            end
          end
        end
      end
      all = 1;
      for (int i = 0; i < 4; i++) if (m_fin[i] == 0) all = 0;
      if (all == 1) m_st = 2;
    end else if (s) begin
      m_mc = (mcv == 0) ? 1 : mcv;
      m_ms = (msv == 0) ? 1 : msv;
      for (int i = 0; i < 4; i++) begin
        m_vc[i] = 0; m_pen[i] = 0; m_fin[i] = 0; m_rank[i] = 0;
      end
      m_nr = 1; m_wv = 0; m_wid = 0; m_st = 1;
      $display("random game start clicks/step %0d steps %0d", m_mc, m_ms);
    end
    m_prev = c;
    m_scan = (m_scan + 1) % 4;
  endtask

  function automatic int exp_status(input int p);
    if (m_fin[p] != 0) return 8 + m_rank[p];
    if (m_pen[p] != 0) return 2;
    if (m_st == 1) return 1;
    return 0;
  endfunction

  function automatic int exp_fin();
    int f = 0;
    for (int i = 0; i < 4; i++) if (m_fin[i] != 0) f |= (1 << i);
    return f;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          mask   red pp pos st      fin     wv wid go
    tbl[0]  = '{'b0100, 0, 2, 0, 'b0001, 'b0000, 0, 0, 0};
    tbl[1]  = '{'b0100, 0, 2, 0, 'b0001, 'b0000, 0, 0, 0};
    tbl[2]  = '{'b0100, 0, 2, 1, 'b0001, 'b0000, 0, 0, 0};
    tbl[3]  = '{'b0100, 0, 2, 1, 'b0001, 'b0000, 0, 0, 0};
    tbl[4]  = '{'b0100, 0, 2, 1, 'b0001, 'b0000, 0, 0, 0};
    tbl[5]  = '{'b1001, 0, 0, 0, 'b0001, 'b0000, 0, 0, 0};
    tbl[6]  = '{'b1001, 0, 0, 0, 'b0001, 'b0000, 0, 0, 0};
    tbl[7]  = '{'b1001, 0, 3, 1, 'b0001, 'b0000, 0, 0, 0};
    tbl[8]  = '{'b1001, 0, 3, 1, 'b0001, 'b0000, 0, 0, 0};
    tbl[9]  = '{'b1001, 0, 0, 1, 'b0001, 'b0000, 0, 0, 0};
    tbl[10] = '{'b1001, 0, 0, 2, 'b1001, 'b1001, 1, 0, 0};
    tbl[11] = '{'b0000, 0, 3, 2, 'b1010, 'b1001, 1, 0, 0};
    tbl[12] = '{'b0100, 0, 2, 2, 'b1011, 'b1101, 1, 0, 0};
    tbl[13] = '{'b0010, 0, 1, 0, 'b0001, 'b1101, 1, 0, 0};
    tbl[14] = '{'b0010, 0, 1, 0, 'b0001, 'b1101, 1, 0, 0};
    tbl[15] = '{'b0010, 0, 1, 1, 'b0001, 'b1101, 1, 0, 0};
    tbl[16] = '{'b0010, 0, 1, 1, 'b0001, 'b1101, 1, 0, 0};
    tbl[17] = '{'b0010, 1, 1, 0, 'b0010, 'b1101, 1, 0, 0};
    tbl[18] = '{'b0010, 0, 1, 0, 'b0001, 'b1101, 1, 0, 0};
    tbl[19] = '{'b0100, 1, 2, 2, 'b1011, 'b1101, 1, 0, 0};
    tbl[20] = '{'b0010, 0, 1, 0, 'b0001, 'b1101, 1, 0, 0};
    tbl[21] = '{'b0010, 0, 1, 1, 'b0001, 'b1101, 1, 0, 0};
    tbl[22] = '{'b0010, 0, 1, 1, 'b0001, 'b1101, 1, 0, 0};
    tbl[23] = '{'b0010, 0, 1, 1, 'b0001, 'b1101, 1, 0, 0};
    tbl[24] = '{'b0010, 0, 1, 2, 'b1100, 'b1111, 1, 0, 1};
    tbl[25] = '{'b1111, 0, 1, 2, 'b1100, 'b1111, 1, 0, 1};
    tbl[26] = '{'b0001, 1, 0, 2, 'b1001, 'b1111, 1, 0, 1};

    rst = 1'b1; start = 1'b0; red = 1'b0;
    max_clicks = '0; max_steps = '0;
    click_a = '0; click_b = '0; click_c = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_go", 32'(go_a), 0);
    chk("rst_wv", 32'(wv_a), 0);
    chk("rst_wid", 32'(wid_a), 0);
    chk("rst_fin", 32'(fin_a), 0);
    chk("rst_sp", 32'(sp_a), 0);
    chk("rst_st", 32'(st_a), 0);
    chk("rst_pos", 32'(pos_a), 0);
    rst = 1'b0;

    // Scanner with N=3, SCAN_DIV=5 from reset release
    chk("scan_b_0", 32'(sp_b), 0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk("scan_b", 32'(sp_b), (k / 5) % 3);
    end
    $display("scanner sequence observed over 20 cycles");

    // Directed game: 3 clicks per step, 2 steps; inputs changed after start
    @(negedge clk);
    max_clicks = 5'd3; max_steps = 3'd2;
    pulse_start();
    max_clicks = 5'd7; max_steps = 3'd1;
    chk("start_go", 32'(go_a), 0);
    peek_a(0, 0, 'b0001, "start_p0");
    for (int k = 0; k < 27; k++) begin
      pulse_a(4'(tbl[k].mask), tbl[k].red[0]);
      chk("row_fin", 32'(fin_a), tbl[k].fin);
      chk("row_wv", 32'(wv_a), tbl[k].wv);
      chk("row_wid", 32'(wid_a), tbl[k].wid);
      chk("row_go", 32'(go_a), tbl[k].go);
      peek_a(tbl[k].pp, tbl[k].pos, tbl[k].st, "row");
      $display("row %0d mask %b red %0d fin %b winner %0d/%0d over %0d",
               k, 4'(tbl[k].mask), tbl[k].red, fin_a, wv_a, wid_a, go_a);
    end
    pulse_start();
    chk("restart_go", 32'(go_a), 0);
    chk("restart_wv", 32'(wv_a), 0);
    chk("restart_wid", 32'(wid_a), 0);
    chk("restart_fin", 32'(fin_a), 0);
    peek_a(1, 0, 'b0001, "restart_p1");
    $display("restart after full game cleared");

    // Randomized play against the model
    @(negedge clk); rst = 1'b1; click_a = '0; red = 1'b0; start = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [3:0] c;
      logic r, s;
      int mcv, msv;
      c = 4'($urandom);
      r = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 19) == 0);
      mcv = $urandom_range(0, 2);
      msv = $urandom_range(0, 2);
      click_a = c; red = r; start = s;
      max_clicks = 5'(mcv); max_steps = 3'(msv);
      model_step(c, r, s, mcv, msv);
      @(posedge clk); #1;
      chk("rand_sp", 32'(sp_a), m_scan);
      chk("rand_pos", 32'(pos_a), (m_fin[m_scan] != 0) ? m_ms : m_vc[m_scan] / m_mc);
      chk("rand_st", 32'(st_a), exp_status(m_scan));
      chk("rand_fin", 32'(fin_a), exp_fin());
      chk("rand_wv", 32'(wv_a), m_wv);
      chk("rand_wid", 32'(wid_a), m_wid);
      chk("rand_go", 32'(go_a), (m_st == 2) ? 1 : 0);
      @(negedge clk);
    end
    click_a = '0; red = 1'b0; start = 1'b0;

    // Stop-at-first mode, N=5: 1 click per step, 2 steps
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    max_clicks = 5'd1; max_steps = 3'd2;
    pulse_start();
    pulse_c(5'b00010);
    pulse_c(5'b01000);
    pulse_c(5'b10000);
    chk("saf_go_early", 32'(go_c), 0);
    chk("saf_wv_early", 32'(wv_c), 0);
    pulse_c(5'b10000);
    chk("saf_go", 32'(go_c), 1);
    chk("saf_fin", 32'(fin_c), 'b10000);
    chk("saf_wv", 32'(wv_c), 1);
    chk("saf_wid", 32'(wid_c), 4);
    peek_c(1, 1, 'b0000, "saf_p1");
    peek_c(3, 1, 'b0000, "saf_p3");
    peek_c(4, 2, 'b1001, "saf_p4");
    pulse_c(5'b00010);
    peek_c(1, 1, 'b0000, "saf_frozen_p1");
    chk("saf_fin_frozen", 32'(fin_c), 'b10000);
    $display("stop-at-first game ended by player 4");
    pulse_start();
    chk("saf_restart_go", 32'(go_c), 0);
    chk("saf_restart_wv", 32'(wv_c), 0);
    pulse_c(5'b00001);
    peek_c(0, 1, 'b0001, "saf_run_p0");

    // Asynchronous reset mid-game, checked before the next clock edge
    @(posedge clk); #2; rst = 1'b1; #1;
    chk("arst_go", 32'(go_c), 0);
    chk("arst_wv", 32'(wv_c), 0);
    chk("arst_wid", 32'(wid_c), 0);
    chk("arst_fin", 32'(fin_c), 0);
    chk("arst_sp", 32'(sp_c), 0);
    chk("arst_pos", 32'(pos_c), 0);
    chk("arst_st", 32'(st_c), 0);
    $display("asynchronous reset mid-game applied");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
